// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_pkg
// Brief    : Shared types and helpers for the sequential fully-connected layer
// Revision : 1.0 - initial release
// ============================================================================
package fc_pkg;

   localparam int c_FRAC_DEFAULT = 10;

   // Layer-pass controller states
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_B_REQ  = 3'd1,
      S_B_WAIT = 3'd2,
      S_W_REQ  = 3'd3,
      S_W_WAIT = 3'd4,
      S_M_WAIT = 3'd5,
      S_STORE  = 3'd6,
      S_FIN    = 3'd7
   } fc_state_t;

   // Largest value representable in a signed field of 'bits' bits
   function automatic longint sat_max(input int bits);
      return (longint'(1) <<< (bits - 1)) - longint'(1);
   endfunction

   // Smallest value representable in a signed field of 'bits' bits
   function automatic longint sat_min(input int bits);
      return -(longint'(1) <<< (bits - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fc_requant.sv
`default_nettype none
// ============================================================================
// Module   : fc_requant
// Brief    : Bias add, re-quantise from 2*FRAC to FRAC fractional bits,
//            saturate to BIT bits and optionally apply ReLU (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module fc_requant
   import fc_pkg::*;
#(
   parameter int BIT  = 16,
   parameter int FRAC = c_FRAC_DEFAULT
)(
   input  logic signed [2*BIT-2:0] mac_result,
   input  logic signed [BIT-1:0]   bias,
   input  logic                    relu,
   output logic        [BIT-1:0]   y,
   output logic                    clipped
);

   localparam int c_W = 2 * BIT;
   localparam logic signed [c_W-1:0] c_MAX = c_W'(sat_max(BIT));
   localparam logic signed [c_W-1:0] c_MIN = c_W'(sat_min(BIT));

   logic signed [c_W-1:0] w_bias_al;
   logic signed [c_W-1:0] w_sum;
   logic signed [c_W-1:0] w_q;

   // Align the bias to the product's 2*FRAC scale, add, shift back, clip, ReLU
   always_comb begin
      w_bias_al = {{BIT{bias[BIT-1]}}, bias} <<< FRAC;
      w_sum     = {mac_result[2*BIT-2], mac_result} + w_bias_al;
      w_q       = w_sum >>> FRAC;
      y         = w_q[BIT-1:0];
      clipped   = 1'b0;
      if (w_q > c_MAX) begin
         y       = c_MAX[BIT-1:0];
         clipped = 1'b1;
      end else if (w_q < c_MIN) begin
         y       = c_MIN[BIT-1:0];
         clipped = 1'b1;
      end
      // A saturated negative value is still negative, so ReLU zeroes it too
      if (relu && w_q[c_W-1]) begin
         y = '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fc_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_seq
// Brief    : Sequential FC layer controller: fetches bias and weight rows from
//            the weight ROM, drives the shared MultAdder one row at a time and
//            re-quantises each neuron into y_vec
// Revision : 1.0 - initial release
// ============================================================================
module fc_layer_seq
   import fc_pkg::*;
#(
   parameter int                BIT    = 16,
   parameter int                FRAC   = c_FRAC_DEFAULT,
   parameter int                N_IN   = 128,
   parameter int                N_OUT  = 128,
   parameter int                ADDR_W = 11,
   parameter logic [ADDR_W-1:0] W_BASE = 11'h401,
   parameter logic [ADDR_W-1:0] B_BASE = 11'h481
)(
   input  logic                    clk,
   input  logic                    iRst_n,
   input  logic                    start,
   input  logic                    act_relu,
   input  logic [N_IN*BIT-1:0]     x_vec,
   output logic                    rom_req,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic                    rom_valid,
   input  logic [N_IN*BIT-1:0]     rom_data,
   output logic                    mac_start,
   output logic [N_IN*BIT-1:0]     mac_opr1,
   output logic [N_IN*BIT-1:0]     mac_opr2,
   input  logic                    mac_valid,
   input  logic [2*BIT-2:0]        mac_result,
   output logic [N_OUT*BIT-1:0]    y_vec,
   output logic                    busy,
   output logic                    done,
   output logic                    sat_flag
);

   localparam int                c_RW       = $clog2(N_OUT + 1);
   localparam logic [c_RW-1:0]   c_ROW_LAST = c_RW'(N_OUT - 1);
   // Rows are stored reversed, so row 0 lives at the top of the block
   localparam logic [ADDR_W-1:0] c_W_FIRST  = ADDR_W'(W_BASE + N_OUT - 1);

   fc_state_t             r_state;
   fc_state_t             w_next;
   logic [c_RW-1:0]       r_row;
   logic                  r_relu;
   logic                  r_done;
   logic                  r_sat;
   logic [ADDR_W-1:0]     r_addr;
   logic [N_OUT*BIT-1:0]  r_bias;
   logic [N_OUT*BIT-1:0]  r_y;
   logic [N_IN*BIT-1:0]   r_opr1;
   logic [N_IN*BIT-1:0]   r_opr2;
   logic [2*BIT-2:0]      r_mac;
   logic                  w_last;
   logic                  w_launch;
   logic [BIT-1:0]        w_y;
   logic                  w_clip;

   assign w_last   = (r_row == c_ROW_LAST);
   assign w_launch = (r_state == S_W_WAIT) && rom_valid;

   fc_requant #(
      .BIT  (BIT),
      .FRAC (FRAC)
   ) u_requant (
      .mac_result (r_mac),
      .bias       (r_bias[r_row*BIT +: BIT]),
      .relu       (r_relu),
      .y          (w_y),
      .clipped    (w_clip)
   );

   // State register
   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic; stalls on rom_valid / mac_valid are unbounded
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start)     w_next = S_B_REQ;
         S_B_REQ:                 w_next = S_B_WAIT;
         S_B_WAIT: if (rom_valid) w_next = S_W_REQ;
         S_W_REQ:                 w_next = S_W_WAIT;
         S_W_WAIT: if (rom_valid) w_next = S_M_WAIT;
         S_M_WAIT: if (mac_valid) w_next = S_STORE;
         S_STORE:                 w_next = w_last ? S_FIN : S_W_REQ;
         S_FIN:                   w_next = S_IDLE;
         default:                 w_next = S_IDLE;
      endcase
   end

   // Outputs; operands bypass their registers in the launch cycle so the
   // MultAdder sees valid data in the same cycle as mac_start
   always_comb begin
      rom_req   = (r_state == S_B_REQ) || (r_state == S_W_REQ);
      mac_start = w_launch;
      busy      = (r_state != S_IDLE) && (r_state != S_FIN);
      mac_opr1  = w_launch ? x_vec    : r_opr1;
      mac_opr2  = w_launch ? rom_data : r_opr2;
      rom_addr  = r_addr;
      y_vec     = r_y;
      done      = r_done;
      sat_flag  = r_sat;
   end

   // Datapath captures: pass setup, bias/operand latching, per-neuron store
   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_row  <= '0;
         r_relu <= 1'b0;
         r_done <= 1'b0;
         r_sat  <= 1'b0;
         r_addr <= '0;
         r_bias <= '0;
         r_y    <= '0;
         r_opr1 <= '0;
         r_opr2 <= '0;
         r_mac  <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_relu <= act_relu;
               r_done <= 1'b0;
               r_sat  <= 1'b0;
               r_addr <= B_BASE;
            end
            S_B_WAIT: if (rom_valid) begin
               r_bias <= rom_data[N_OUT*BIT-1:0];
               r_row  <= '0;
               r_addr <= c_W_FIRST;
            end
            S_W_WAIT: if (rom_valid) begin
               r_opr1 <= x_vec;
               r_opr2 <= rom_data;
            end
            S_M_WAIT: if (mac_valid) begin
               r_mac <= mac_result;
            end
            S_STORE: begin
               r_y[r_row*BIT +: BIT] <= w_y;
               r_sat                 <= r_sat | w_clip;
               r_row                 <= r_row + 1'b1;
               if (w_last) r_done <= 1'b1;
               else        r_addr <= r_addr - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
